// File: rtl/sdam.sv
// Serial Data Address Module: write-only two-wire serial receiver.
// Decodes start, write opcode, LSB-first address and data; pulses valid.
module sdam #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              scl,
    input  logic              reset,
    input  logic              sda,
    output logic              avalid,
    output logic [ADDR_W-1:0] aout,
    output logic              dvalid,
    output logic [DATA_W-1:0] dout
);

    localparam int CNT_W = 4;
    localparam int AI_W  = $clog2(ADDR_W);
    localparam int DI_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        ADDR,
        DATA
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   data_d;
    logic [ADDR_W-1:0]   aout_q;
    logic [DATA_W-1:0]   dout_q;
    logic                avalid_q;
    logic                dvalid_q;

    // Field contents with the bit sampled at this edge already inserted,
    // so the final data bit lands in dout on the same edge.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        addr_d[cnt_q[AI_W-1:0]] = sda;
        data_d[cnt_q[DI_W-1:0]] = sda;
    end

    always_ff @(posedge scl) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            aout_q   <= '0;
            dout_q   <= '0;
            avalid_q <= 1'b0;
            dvalid_q <= 1'b0;
        end else begin
            avalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Only a clean 0 starts a frame; X/Z stays idle.
                    if (sda == 1'b0) begin
                        state_q <= CMD;
                    end
                end
                CMD: begin
                    cnt_q   <= '0;
                    state_q <= (sda == 1'b1) ? ADDR : IDLE;
                end
                ADDR: begin
                    addr_q <= addr_d;
                    if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                        cnt_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    data_q <= data_d;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_q    <= '0;
                        aout_q   <= addr_q;
                        dout_q   <= data_d;
                        avalid_q <= 1'b1;
                        dvalid_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign avalid = avalid_q;
    assign dvalid = dvalid_q;
    assign aout   = aout_q;
    assign dout   = dout_q;

endmodule

// File: tb/tb_sdam.sv
// Self-checking bench for sdam: table-driven frames plus reset,
// back-to-back and idle-hold sequences.
module tb_sdam;

    logic        scl = 1'b0;
    logic        reset = 1'b1;
    logic        sda = 1'b1;
    logic        avalid;
    logic        dvalid;
    logic [7:0]  aout;
    logic [15:0] dout;

    int n_cmp  = 0;
    int n_err  = 0;
    int pulses = 0;

    logic [7:0]  exp_a = 8'h00;
    logic [15:0] exp_d = 16'h0000;

    typedef struct {
        logic        op;
        logic [7:0]  a;
        logic [15:0] d;
        logic        pulse;
    } vec_t;

    vec_t tbl[6];

    sdam #(.ADDR_W(8), .DATA_W(16)) dut (
        .scl    (scl),
        .reset  (reset),
        .sda    (sda),
        .avalid (avalid),
        .aout   (aout),
        .dvalid (dvalid),
        .dout   (dout)
    );

    always #5 scl = ~scl;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // avalid and dvalid must always agree; also count pulses.
    always @(posedge scl) begin
        #1;
        if (!reset) begin
            n_cmp++;
            if (avalid !== dvalid) begin
                n_err++;
                $display("FAIL pair: got avalid=%b dvalid=%b required equal",
                         avalid, dvalid);
            end
            if (avalid === 1'b1) pulses++;
        end
    end

    task automatic send_bit(input logic b);
        @(negedge scl);
        sda = b;
        @(posedge scl);
        #1;
    endtask

    task automatic send_frame(input logic op, input logic [7:0] a,
                              input logic [15:0] d);
        send_bit(1'b0);
        chk("valid_clear", {30'd0, avalid, dvalid}, 32'd0);
        send_bit(op);
        for (int i = 0; i < 8; i++) send_bit(a[i]);
        for (int i = 0; i < 16; i++) send_bit(d[i]);
    endtask

    task automatic check_result(input string name, input logic pulse,
                                input logic [7:0] a, input logic [15:0] d);
        if (pulse) begin
            exp_a = a;
            exp_d = d;
        end
        chk({name, "_avalid"}, {31'd0, avalid}, {31'd0, pulse});
        chk({name, "_dvalid"}, {31'd0, dvalid}, {31'd0, pulse});
        chk({name, "_aout"}, {24'd0, aout}, {24'd0, exp_a});
        chk({name, "_dout"}, {16'd0, dout}, {16'd0, exp_d});
    endtask

    function automatic logic [15:0] pat(input int i);
        logic [15:0] v;
        v = 16'(i) * 16'h1357;
        return v ^ 16'hC3A5;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        tbl[0] = '{1'b1, 8'h00, 16'hA5C3, 1'b1};
        tbl[1] = '{1'b0, 8'hFF, 16'hFFFF, 1'b0};
        tbl[2] = '{1'b1, 8'h1F, 16'hFFFF, 1'b1};
        tbl[3] = '{1'b1, 8'h5A, 16'h0000, 1'b1};
        tbl[4] = '{1'b1, 8'hFF, 16'h8001, 1'b1};
        tbl[5] = '{1'b0, 8'hFF, 16'hFFFF, 1'b0};

        reset = 1'b1;
        sda   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1);
            chk("rst_outs", {6'd0, avalid, dvalid, aout, dout}, 32'd0);
        end
        reset = 1'b0;
        send_bit(1'b1);
        chk("post_rst", {6'd0, avalid, dvalid, aout, dout}, 32'd0);

        for (int r = 0; r < 6; r++) begin
            send_frame(tbl[r].op, tbl[r].a, tbl[r].d);
            check_result($sformatf("row%0d", r), tbl[r].pulse,
                         tbl[r].a, tbl[r].d);
        end
        send_bit(1'b1);

        p0 = pulses;
        for (int i = 0; i < 32; i++) begin
            send_frame(1'b1, 8'(i), pat(i));
            check_result($sformatf("b2b%0d", i), 1'b1, 8'(i), pat(i));
        end
        send_bit(1'b1);
        chk("b2b_count", 32'(pulses - p0), 32'd32);

        p0 = pulses;
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        @(negedge scl);
        reset = 1'b1;
        sda   = 1'b1;
        @(posedge scl);
        #1;
        exp_a = 8'h00;
        exp_d = 16'h0000;
        chk("midrst_outs", {6'd0, avalid, dvalid, aout, dout}, 32'd0);
        reset = 1'b0;
        send_frame(1'b1, 8'h80, 16'h0001);
        check_result("after_rst", 1'b1, 8'h80, 16'h0001);
        send_bit(1'b1);
        chk("midrst_count", 32'(pulses - p0), 32'd1);

        for (int i = 0; i < 100; i++) begin
            send_bit(1'b1);
            chk("idle_hold", {6'd0, avalid, dvalid, aout, dout},
                {6'd0, 2'b00, exp_a, exp_d});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
